// File: rtl/touch_pen_intr_servicer_pkg.sv
// Shared definitions for the touch-pen interrupt servicer: FSM state encoding
// and the register map of the PIO slave being serviced.
package touch_pen_intr_servicer_pkg;

    // state       | meaning
    // ST_INIT     | write 1 to the irq mask register
    // ST_IDLE     | wait for irq rise or poll expiry
    // ST_RD_CAP   | read edge-capture (access cycle)
    // ST_CAP_WAIT | wait out read latency, latch capture bit
    // ST_CLR      | write edge-capture to clear it
    // ST_RD_DAT   | read pen level (access cycle)
    // ST_DAT_WAIT | wait out read latency, decide on event
    // ST_EMIT     | present event until consumer accepts
    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_CAP,
        ST_CAP_WAIT,
        ST_CLR,
        ST_RD_DAT,
        ST_DAT_WAIT,
        ST_EMIT
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

endpackage

// File: rtl/touch_pen_intr_servicer_poll_timer.sv
// Background poll timer: counts idle cycles, saturates at POLL_CYCLES-1 and
// flags expiry there. Cleared whenever a service starts.
module touch_pen_poll_timer #(
    parameter int POLL_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    input  logic i_clr,
    output logic o_expired
);
    localparam int TW = $clog2(POLL_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(POLL_CYCLES - 1);

    logic [TW-1:0] r_count;

    assign o_expired = (r_count == LAST);

    // Count while running, hold at the terminal value, clear on request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_run && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/touch_pen_intr_servicer.sv
// Avalon-MM master that services the touch-pen PIO interrupt in hardware:
// enables the mask, then on irq rise or poll expiry reads/clears edge-capture,
// reads the pen level and emits at most one event per service.
module touch_pen_intr_servicer
    import touch_pen_intr_servicer_pkg::*;
#(
    parameter int POLL_CYCLES  = 1000,
    parameter int CNT_W        = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq_in,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_pen_down,
    output logic             evt_edge,
    output logic [CNT_W-1:0] evt_press_count
);
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LW-1:0] LAT_LOAD = LW'(READ_LATENCY - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_irq_q;
    logic [LW-1:0]    r_lat;
    logic             r_cap;
    logic             r_last_level;
    logic             r_pen;
    logic             r_edge;
    logic [CNT_W-1:0] r_press;
    logic             w_trigger;
    logic             w_expired;
    logic             w_lat_done;
    logic             w_rd_bit;
    logic             w_emit;
    logic             w_unused;

    assign w_rd_bit   = avm_readdata[0];
    assign w_unused   = ^avm_readdata[31:1];
    assign w_lat_done = (r_lat == '0);
    assign w_emit     = (r_state == ST_DAT_WAIT) && w_lat_done &&
                        (r_cap || (w_rd_bit != r_last_level));

    assign evt_valid       = (r_state == ST_EMIT);
    assign evt_pen_down    = r_pen;
    assign evt_edge        = r_edge;
    assign evt_press_count = r_press;

    touch_pen_poll_timer #(
        .POLL_CYCLES(POLL_CYCLES)
    ) u_poll_timer (
        .clk       (clk),
        .reset     (reset),
        .i_run     (r_state == ST_IDLE),
        .i_clr     (w_trigger),
        .o_expired (w_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and bus outputs; bus is forced idle while reset is held.
    always_comb begin
        w_next         = r_state;
        w_trigger      = 1'b0;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = ADDR_DATA;
        avm_writedata  = 32'd0;
        case (r_state)
            ST_INIT: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_MASK;
                avm_writedata  = 32'd1;
                w_next         = ST_IDLE;
            end
            ST_IDLE: begin
                w_trigger = (irq_in && !r_irq_q) || w_expired;
                if (w_trigger) w_next = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                avm_chipselect = 1'b1;
                avm_address    = ADDR_CAP;
                w_next         = ST_CAP_WAIT;
            end
            ST_CAP_WAIT: begin
                if (w_lat_done) w_next = w_rd_bit ? ST_CLR : ST_RD_DAT;
            end
            ST_CLR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_CAP;
                avm_writedata  = 32'd1;
                w_next         = ST_RD_DAT;
            end
            ST_RD_DAT: begin
                avm_chipselect = 1'b1;
                avm_address    = ADDR_DATA;
                w_next         = ST_DAT_WAIT;
            end
            ST_DAT_WAIT: begin
                if (w_lat_done) w_next = w_emit ? ST_EMIT : ST_IDLE;
            end
            ST_EMIT: begin
                if (evt_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_INIT;
        endcase
        if (reset) begin
            avm_chipselect = 1'b0;
            avm_write_n    = 1'b1;
            avm_address    = ADDR_DATA;
            avm_writedata  = 32'd0;
        end
    end

    // Read-latency down-counter, loaded in each read access cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lat <= '0;
        end else if (r_state == ST_RD_CAP || r_state == ST_RD_DAT) begin
            r_lat <= LAT_LOAD;
        end else if ((r_state == ST_CAP_WAIT || r_state == ST_DAT_WAIT) && !w_lat_done) begin
            r_lat <= r_lat - 1'b1;
        end
    end

    // Datapath: irq history, capture bit, event fields, press counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_q      <= 1'b0;
            r_cap        <= 1'b0;
            r_last_level <= 1'b0;
            r_pen        <= 1'b0;
            r_edge       <= 1'b0;
            r_press      <= '0;
        end else begin
            r_irq_q <= irq_in;
            if (r_state == ST_CAP_WAIT && w_lat_done) r_cap <= w_rd_bit;
            if (w_emit) begin
                r_pen  <= w_rd_bit;
                r_edge <= r_cap;
                if (w_rd_bit && !r_last_level) r_press <= r_press + 1'b1;
            end
            if (r_state == ST_EMIT && evt_ready) r_last_level <= r_pen;
        end
    end

endmodule

// File: tb/tb_touch_pen_intr_servicer.sv
// Bench for touch_pen_intr_servicer: PIO slave model with any-edge sticky
// capture, directed scenarios, then randomized pen activity scored against an
// event-level model of reported levels and press counts.
module tb_touch_pen_intr_servicer;
    localparam int POLL  = 1000;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             irq_in;
    logic [1:0]       avm_address;
    logic             avm_chipselect;
    logic             avm_write_n;
    logic [31:0]      avm_writedata;
    logic [31:0]      avm_readdata;
    logic             evt_valid;
    logic             evt_ready = 1'b0;
    logic             evt_pen_down;
    logic             evt_edge;
    logic [CNT_W-1:0] evt_press_count;

    // slave model state
    logic        pen = 1'b0;
    logic        pen_q = 1'b0;
    logic        glitch = 1'b0;
    logic        mask;
    logic        cap_reg;
    logic [31:0] rdata;
    logic        rec_lvl, rec_cap;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_wr_mask = 0, n_rd_cap = 0, n_wr_cap = 0, n_rd_dat = 0, n_emit_bus = 0;

    // event-level reference model
    int   exp_press = 0;
    logic last_rep = 1'b0;

    always #5 clk = ~clk;

    touch_pen_intr_servicer #(
        .POLL_CYCLES(POLL), .CNT_W(CNT_W), .READ_LATENCY(1)
    ) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_pen_down(evt_pen_down), .evt_edge(evt_edge),
        .evt_press_count(evt_press_count)
    );

    assign irq_in       = (pen & mask) | glitch;
    assign avm_readdata = rdata;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        pen_q <= pen;
    end

    // PIO slave: mask, any-edge sticky capture (edge beats clear), 1-cycle reads
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mask    <= 1'b0;
            cap_reg <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            if (avm_chipselect && !avm_write_n && avm_address == 2'd2) mask <= avm_writedata[0];
            if (avm_chipselect && !avm_write_n && avm_address == 2'd3) cap_reg <= 1'b0;
            if (pen != pen_q) cap_reg <= 1'b1;
            if (avm_chipselect && avm_write_n) begin
                case (avm_address)
                    2'd0: begin rdata <= {31'd0, pen};     rec_lvl <= pen;     end
                    2'd2:       rdata <= {31'd0, mask};
                    2'd3: begin rdata <= {31'd0, cap_reg}; rec_cap <= cap_reg; end
                    default:    rdata <= 32'd0;
                endcase
            end
        end
    end

    // bus access monitor
    always @(negedge clk) begin
        if (!reset && avm_chipselect) begin
            if (!avm_write_n && avm_address == 2'd2) n_wr_mask++;
            if (!avm_write_n && avm_address == 2'd3) n_wr_cap++;
            if (avm_write_n && avm_address == 2'd3) n_rd_cap++;
            if (avm_write_n && avm_address == 2'd0) n_rd_dat++;
            if (evt_valid) n_emit_bus++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic score(input string tag, input logic exp_pen, input logic exp_edge);
        if (exp_pen && !last_rep) exp_press = (exp_press + 1) % (1 << CNT_W);
        last_rep = exp_pen;
        check({tag, " pen_down"}, evt_pen_down, exp_pen);
        check({tag, " edge"}, evt_edge, exp_edge);
        check({tag, " press_count"}, evt_press_count, exp_press);
    endtask

    task automatic handle_event(input string tag, input logic exp_pen, input logic exp_edge);
        score(tag, exp_pen, exp_edge);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        check({tag, " released"}, evt_valid, 1'b0);
    endtask

    task automatic wait_event(input string tag, input int limit, input logic exp_pen, input logic exp_edge);
        int k = 0;
        while (!evt_valid && k < limit) begin
            @(negedge clk);
            k++;
        end
        check({tag, " arrived"}, evt_valid, 1'b1);
        if (evt_valid) handle_event(tag, exp_pen, exp_edge);
    endtask

    task automatic wait_cap_read(input string tag, input int limit, output int at);
        int k = 0;
        at = -1;
        while (k < limit) begin
            @(negedge clk);
            k++;
            if (avm_chipselect && avm_write_n && avm_address == 2'd3) begin
                at = cyc;
                break;
            end
        end
        check({tag, " cap read seen"}, (at >= 0), 1'b1);
    endtask

    task automatic check_init_write(input string tag);
        #1;
        check({tag, " init cs"}, avm_chipselect, 1'b1);
        check({tag, " init write_n"}, avm_write_n, 1'b0);
        check({tag, " init addr"}, avm_address, 2'd2);
        check({tag, " init data"}, avm_writedata, 32'd1);
        @(negedge clk);
        check({tag, " init cs one cycle"}, avm_chipselect, 1'b0);
    endtask

    initial begin
        int t_a, t_b, base_cap, base_dat, base_wr, total;
        bit seen;

        // 1: reset values and mask initialisation
        repeat (3) @(negedge clk);
        check("rst cs", avm_chipselect, 1'b0);
        check("rst write_n", avm_write_n, 1'b1);
        check("rst addr", avm_address, 2'd0);
        check("rst wdata", avm_writedata, 32'd0);
        check("rst evt_valid", evt_valid, 1'b0);
        check("rst pen_down", evt_pen_down, 1'b0);
        check("rst edge", evt_edge, 1'b0);
        check("rst press", evt_press_count, 2'd0);
        reset = 1'b0;
        check_init_write("t1");
        repeat (3) @(negedge clk);
        check("t1 idle bus", avm_chipselect, 1'b0);

        // 2: pen down via irq, latency 6 cycles from the rise
        pen = 1'b1;
        repeat (5) @(negedge clk);
        check("t2 not yet valid", evt_valid, 1'b0);
        @(negedge clk);
        check("t2 valid at 6", evt_valid, 1'b1);
        handle_event("t2", 1'b1, 1'b1);
        check("t2 cap reads", n_rd_cap, 1);
        check("t2 cap writes", n_wr_cap, 1);
        check("t2 data reads", n_rd_dat, 1);
        check("t2 mask writes", n_wr_mask, 1);

        // 3: pen up, no irq -> found by poll
        pen = 1'b0;
        wait_event("t3", POLL + 100, 1'b0, 1'b1);
        check("t3 cap writes", n_wr_cap, 2);

        // 5a: poll period, then irq rise on the expiry cycle
        wait_cap_read("t5 poll1", POLL + 100, t_a);
        wait_cap_read("t5 poll2", POLL + 100, t_b);
        check("t5 poll period", t_b - t_a, POLL + 4);
        repeat (POLL + 3) @(negedge clk);
        base_cap = n_rd_cap;
        pen = 1'b1;
        wait_event("t5 coincide", 20, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        check("t5 single cap read", n_rd_cap - base_cap, 1);
        pen = 1'b0;
        wait_event("t5 release", POLL + 100, 1'b0, 1'b1);

        // 4: back-pressure, pen toggles twice while the event is held
        pen = 1'b1;
        for (int k = 0; k < 20 && !evt_valid; k++) @(negedge clk);
        check("t4 held event up", evt_valid, 1'b1);
        total = n_wr_mask + n_rd_cap + n_wr_cap + n_rd_dat;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) pen = 1'b0;
            if (i == 30) pen = 1'b1;
            @(negedge clk);
        end
        check("t4 still valid", evt_valid, 1'b1);
        check("t4 bus silent", n_wr_mask + n_rd_cap + n_wr_cap + n_rd_dat - total, 0);
        handle_event("t4 first", 1'b1, 1'b1);
        wait_event("t4 merged", POLL + 100, 1'b1, 1'b1);

        // 5b: glitch irq, no capture, level unchanged
        pen = 1'b0;
        wait_event("t5 down", POLL + 100, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        base_cap = n_rd_cap; base_dat = n_rd_dat; base_wr = n_wr_cap;
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (evt_valid) seen = 1'b1;
        end
        check("glitch cap read", n_rd_cap - base_cap, 1);
        check("glitch data read", n_rd_dat - base_dat, 1);
        check("glitch no clear", n_wr_cap - base_wr, 0);
        check("glitch no event", seen, 1'b0);

        // 6: reset in the clear cycle, re-init, counter wrap
        pen = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (avm_chipselect && !avm_write_n && avm_address == 2'd3) break;
        end
        check("t6 in clr", avm_chipselect && !avm_write_n && avm_address == 2'd3, 1'b1);
        reset = 1'b1;
        #1;
        check("t6 cs drops", avm_chipselect, 1'b0);
        check("t6 write_n idle", avm_write_n, 1'b1);
        check("t6 addr idle", avm_address, 2'd0);
        pen = 1'b0;
        repeat (3) @(negedge clk);
        check("t6 press reset", evt_press_count, 2'd0);
        exp_press = 0;
        last_rep  = 1'b0;
        reset = 1'b0;
        check_init_write("t6");
        for (int p = 0; p < 5; p++) begin
            pen = 1'b1;
            wait_event("t6 press", 20, 1'b1, 1'b1);
            pen = 1'b0;
            wait_event("t6 lift", POLL + 100, 1'b0, 1'b1);
        end
        check("t6 wrap count", evt_press_count, 2'd1);

        // randomized pen activity with random back-pressure
        for (int c = 0; c < 6500; c++) begin
            @(negedge clk);
            if (evt_valid && evt_ready) score("rand", rec_lvl, rec_cap);
            evt_ready = 1'($urandom_range(0, 1));
            if (c < 4000 && $urandom_range(0, 149) == 0) pen = ~pen;
        end
        // leave the model aligned if an event is still pending
        evt_ready = 1'b0;
        @(negedge clk);
        if (evt_valid) handle_event("rand tail", rec_lvl, rec_cap);
        check("rand converged level", last_rep, pen);
        check("no bus during emit", n_emit_bus, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
